ifu: RTL and testbench

Instruction fetch unit feeding the decode stage: holds the PC, issues in-order requests to instruction memory over a req/gnt/rvalid handshake, buffers returned words with their PCs, and presents one registered instruction per cycle as `id_i_pc`/`id_i_inst`/`id_i_inst_vld`. Supports a decode-side stall and a redirect (flush) input for upcoming branch/jump support.

---
 rtl/ifu_pkg.sv | 22 ++
 rtl/ifu_fifo.sv | 57 +++++
 rtl/ifu.sv | 150 +++++++++++++++
 tb/tb_ifu.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: word sizes, PC step,
// the buffered fetch entry layout and a PC alignment helper.
package ifu_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 32;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;
  localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'd4;
  localparam logic [INST_DATA_W-1:0] INST_NOP  = 32'h0000_0013;

  // One returned instruction together with the address it was fetched from.
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_DATA_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with a combinational head, occupancy count and a clear
// that empties it in one cycle. Push when full and pop when empty are ignored.
module ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   clear,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: keeps the PC, issues in-order fetches to instruction
// memory, buffers returned words with their PCs and presents one per cycle.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                     DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] flush_pc,
  output logic                   imem_req,
  output logic [INST_ADDR_W-1:0] imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INST_DATA_W-1:0] imem_rdata,
  output logic [INST_ADDR_W-1:0] id_i_pc,
  output logic                   id_i_inst_vld,
  output logic [INST_DATA_W-1:0] id_i_inst
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a fetch is transferred on a cycle with imem_req && imem_gnt;
  // imem_rvalid returns one word per cycle in request order with no
  // back-pressure, so a slot is reserved at grant time. Decode takes the
  // presented instruction on any cycle with id_i_inst_vld && !stall.

  logic [INST_ADDR_W-1:0] pc;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          drop_cnt;

  logic                   fire;
  logic                   rsp_drop;
  logic                   rsp_keep;
  logic [CW:0]            credit_used;

  logic [INST_ADDR_W-1:0] tag_head;
  logic                   tag_full;
  logic                   tag_empty;
  logic [CW-1:0]          tag_count;

  fetch_entry_t           buf_wdata;
  fetch_entry_t           buf_head;
  logic                   buf_pop;
  logic                   buf_full;
  logic                   buf_empty;
  logic [CW-1:0]          buf_count;

  logic                   unused_status;

  assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req    = rst_ && !flush && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = pc;
  assign fire        = imem_req && imem_gnt;

  assign rsp_drop  = imem_rvalid && (drop_cnt != '0);
  assign rsp_keep  = imem_rvalid && (drop_cnt == '0) && !flush;
  assign buf_wdata = '{pc: tag_head, inst: imem_rdata};
  assign buf_pop   = !stall && !buf_empty && !flush;

  assign unused_status = &{1'b0, tag_full, tag_empty, tag_count, buf_full};

  ifu_fifo #(
    .WIDTH (INST_ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .rst_  (rst_),
    .push  (fire),
    .wdata (pc),
    .pop   (rsp_keep),
    .clear (flush),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  ifu_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk   (clk),
    .rst_  (rst_),
    .push  (rsp_keep),
    .wdata (buf_wdata),
    .pop   (buf_pop),
    .clear (flush),
    .rdata (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= align_pc(flush_pc);
    end else if (fire) begin
      pc <= pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      outstanding <= '0;
    end else begin
      case ({fire, imem_rvalid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // outstanding already includes words still owed to an earlier flush, so
  // after a redirect every remaining in-flight word is to be dropped.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= outstanding - CW'(imem_rvalid);
    end else if (rsp_drop) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      id_i_pc       <= ZERO_WORD;
      id_i_inst     <= ZERO_WORD;
      id_i_inst_vld <= 1'b0;
    end else if (flush) begin
      id_i_inst_vld <= 1'b0;
    end else if (!stall) begin
      if (buf_pop) begin
        id_i_pc       <= buf_head.pc;
        id_i_inst     <= buf_head.inst;
        id_i_inst_vld <= 1'b1;
      end else begin
        id_i_inst_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: table-driven checks on a RESET_PC near the top of memory,
// plus a scoreboarded memory model driving stream, stall, flush and random runs.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] W_DATA = 32'h1234_5678;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_;
  logic        stall, flush;
  logic [31:0] flush_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] id_i_pc, id_i_inst;
  logic        id_i_inst_vld;

  logic        w_gnt, w_rvalid, w_req, w_vld;
  logic [31:0] w_addr, w_pc, w_inst;
  logic        w_stall = 1'b0;
  logic        w_flush = 1'b0;
  logic [31:0] w_flush_pc = 32'h0;
  logic [31:0] w_rdata = W_DATA;

  ifu #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst_(rst_), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_i_pc(id_i_pc), .id_i_inst_vld(id_i_inst_vld), .id_i_inst(id_i_inst)
  );

  ifu #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk(clk), .rst_(rst_), .stall(w_stall), .flush(w_flush), .flush_pc(w_flush_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .id_i_pc(w_pc), .id_i_inst_vld(w_vld), .id_i_inst(w_inst)
  );

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_pc;
  } wrap_vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  wrap_vec_t   wtbl[14];
  pend_t       pend_q[$];
  logic [63:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int  gnt_pct = 0;
  int  lat_min = 1;
  int  lat_max = 1;
  bit  hold    = 1'b0;
  bit  d_stall = 1'b0;
  bit  d_flush = 1'b0;
  logic [31:0] d_flush_pc = 32'h0;
  bit  wd_gnt = 1'b0;
  bit  wd_rvalid = 1'b0;

  bit          frz_valid = 1'b0;
  logic [31:0] frz_pc, frz_inst;
  logic        frz_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // One bench cycle: check held outputs, drive inputs, run the memory model
  // and the scoreboard. Returns mid-cycle with outputs of this cycle stable.
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    if (frz_valid) begin
      chk("stall_hold_pc", id_i_pc, frz_pc);
      chk("stall_hold_inst", id_i_inst, frz_inst);
      chk("stall_hold_vld", id_i_inst_vld, frz_vld);
    end
    stall    = d_stall;
    flush    = d_flush;
    flush_pc = d_flush_pc;
    w_gnt    = wd_gnt;
    w_rvalid = wd_rvalid;
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (!hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_q[0].addr ^ KEY;
      void'(pend_q.pop_front());
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (flush) begin
      chk("flush_no_req", imem_req, 1'b0);
      exp_q.delete();
    end else if (id_i_inst_vld && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual pc=%h required no instruction (cycle %0d)", id_i_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", id_i_pc, e[63:32]);
        chk("sb_inst", id_i_inst, e[31:0]);
      end
    end
    if (imem_req && imem_gnt) begin
      pend_q.push_back('{imem_addr, cyc + $urandom_range(lat_max, lat_min)});
      exp_q.push_back({imem_addr, imem_addr ^ KEY});
    end
    frz_valid = stall && !flush;
    frz_pc    = id_i_pc;
    frz_inst  = id_i_inst;
    frz_vld   = id_i_inst_vld;
    cyc++;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    pend_q.delete();
    exp_q.delete();
    stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    d_stall = 1'b0; d_flush = 1'b0; d_flush_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    w_gnt = 1'b0; w_rvalid = 1'b0; wd_gnt = 1'b0; wd_rvalid = 1'b0;
    frz_valid = 1'b0;
    hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", id_i_pc, 32'h0);
    chk("rst_inst", id_i_inst, 32'h0);
    chk("rst_vld", id_i_inst_vld, 1'b0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #2 rst_ = 1'b1;
    cyc = 0;
  endtask

  task automatic drain();
    gnt_pct = 0;
    d_stall = 1'b0;
    hold    = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle();
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic wait_first(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle();
      if (id_i_inst_vld) begin
        seen = 1'b1;
        chk(name, id_i_pc, exp_pc);
      end
    end
    if (!seen) fail_now({name, "_timeout"});
  endtask

  task automatic set_w(input int i, input logic g, input logic r, input logic req,
                       input logic [31:0] addr, input logic vld, input logic [31:0] pc);
    wtbl[i] = '{g, r, req, addr, vld, pc};
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    set_w(0,  1, 0, 1, 32'hFFFF_FFF8, 0, 32'h0);
    set_w(1,  1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    set_w(2,  1, 0, 1, 32'h0000_0000, 0, 32'h0);
    set_w(3,  1, 0, 1, 32'h0000_0004, 0, 32'h0);
    set_w(4,  1, 1, 0, 32'h0000_0008, 0, 32'h0);
    set_w(5,  0, 0, 0, 32'h0000_0008, 0, 32'h0);
    set_w(6,  0, 0, 1, 32'h0000_0008, 1, 32'hFFFF_FFF8);
    set_w(7,  1, 0, 1, 32'h0000_0008, 0, 32'hFFFF_FFF8);
    set_w(8,  0, 1, 0, 32'h0000_000C, 0, 32'hFFFF_FFF8);
    set_w(9,  0, 0, 0, 32'h0000_000C, 0, 32'hFFFF_FFF8);
    set_w(10, 0, 0, 1, 32'h0000_000C, 1, 32'hFFFF_FFFC);
    set_w(11, 0, 1, 1, 32'h0000_000C, 0, 32'hFFFF_FFFC);
    set_w(12, 0, 0, 1, 32'h0000_000C, 0, 32'hFFFF_FFFC);
    set_w(13, 0, 0, 1, 32'h0000_000C, 1, 32'h0000_0000);

    do_reset();
    gnt_pct = 0;
    for (int i = 0; i < 14; i++) begin
      wd_gnt    = wtbl[i].gnt;
      wd_rvalid = wtbl[i].rvalid;
      cycle();
      chk($sformatf("wrap_req_%0d", i), w_req, wtbl[i].exp_req);
      chk($sformatf("wrap_addr_%0d", i), w_addr, wtbl[i].exp_addr);
      chk($sformatf("wrap_vld_%0d", i), w_vld, wtbl[i].exp_vld);
      chk($sformatf("wrap_pc_%0d", i), w_pc, wtbl[i].exp_pc);
    end
    chk("wrap_inst", w_inst, W_DATA);
    wd_gnt = 1'b0;
    wd_rvalid = 1'b0;

    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (k == 0) begin
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);
      end
      chk($sformatf("stream_vld_%0d", k), id_i_inst_vld, (k >= 3) ? 32'd1 : 32'd0);
    end

    d_stall = 1'b1;
    for (int s = 0; s < 6; s++) begin
      cycle();
      if (s >= 4) chk("stall_req_low", imem_req, 1'b0);
    end
    d_stall = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    drain();

    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    chk("pre_flush_pending", pend_q.size(), 32'd3);
    d_flush = 1'b1;
    d_flush_pc = 32'h0000_0102;
    cycle();
    d_flush = 1'b0;
    hold = 1'b0;
    cycle();
    chk("post_flush_req", imem_req, 1'b1);
    chk("post_flush_addr", imem_addr, 32'h0000_0100);
    wait_first("flush_first_pc", 32'h0000_0100);
    drain();

    gnt_pct = 100; lat_min = 1; lat_max = 1;
    for (int k = 0; k < 6; k++) cycle();
    d_stall = 1'b1;
    d_flush = 1'b1;
    d_flush_pc = 32'h0000_0200;
    cycle();
    d_stall = 1'b0;
    d_flush = 1'b0;
    cycle();
    chk("flush_stall_vld_low", id_i_inst_vld, 1'b0);
    wait_first("flush_stall_first_pc", 32'h0000_0200);
    drain();

    gnt_pct = 60; lat_min = 1; lat_max = 5;
    for (int k = 0; k < 300; k++) begin
      d_stall = ($urandom_range(3) == 0);
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
